// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the monocycle core:
// loader state encoding, default memory depth and the length-legality rule.
package imem_loader_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_CHECK,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    // A session length is usable when it is non-zero and fits in the memory.
    function automatic logic len_ok(input logic [15:0] n, input int depth);
        return (n != 16'd0) && (int'({16'd0, n}) <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian 4-byte packer: byte k of a word lands in bits 8k+7:8k.
// 'word' already includes the byte being accepted, so the caller can capture it on the same edge.
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        full
);

    logic [31:0] lanes_q;
    logic [1:0]  count_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        word = lanes_q;
        if (byte_valid) begin
            word[{count_q, 3'b000} +: 8] = byte_data;
        end
    end

    assign full = byte_valid && (count_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_n) begin
            lanes_q <= '0;
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (byte_valid) begin
            lanes_q <= word;
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader that rewrites instruction memory while holding the core:
// 16-bit little-endian word count, then that many little-endian 32-bit words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    loader_state_e state_q, state_d;

    logic [15:0] len_q;
    logic [15:0] word_index_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        start_ok;
    logic        asm_valid;
    logic        asm_clear;
    logic        asm_full;
    logic [31:0] asm_word;
    logic        last_word;

    // Ready depends on state only, so the handshake never loops through rx_valid.
    assign rx_ready  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
    assign accept    = rx_valid && rx_ready;
    assign start_ok  = (state_q == ST_IDLE) && start;
    assign asm_valid = accept && (state_q == ST_DATA);
    assign asm_clear = start_ok || (state_q == ST_WRITE);
    assign last_word = (word_index_q + 16'd1) == len_q;

    byte_assembler u_byte_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .word       (asm_word),
        .full       (asm_full)
    );

    always_comb begin
        state_d = state_q;
        imem_we = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: if (rx_valid) state_d = ST_LEN_HI;
            ST_LEN_HI: if (rx_valid) state_d = ST_CHECK;
            ST_CHECK:  state_d = len_ok(len_q, DEPTH_WORDS) ? ST_DATA : ST_ERR;
            ST_DATA:   if (asm_full) state_d = ST_WRITE;
            ST_WRITE: begin
                imem_we = 1'b1;
                state_d = last_word ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu_hold   = busy;
    assign err        = err_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_index_q <= '0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                err_q        <= 1'b0;
                word_index_q <= '0;
            end
            if ((state_q == ST_CHECK) && (state_d == ST_ERR)) begin
                err_q <= 1'b1;
            end
            if (accept && (state_q == ST_LEN_LO)) len_q[7:0]  <= rx_data;
            if (accept && (state_q == ST_LEN_HI)) len_q[15:8] <= rx_data;
            // Address and data are captured with the fourth byte so they are valid in WRITE.
            if (asm_full) begin
                addr_q  <= {14'b0, word_index_q, 2'b00};
                wdata_q <= asm_word;
            end
            if (state_q == ST_WRITE) begin
                word_index_q <= word_index_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default-depth instance and a 4-word instance,
// driven one at a time, each checked against a session-level reference model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int SMALL_DEPTH = 4;

    typedef logic [7:0] byte_q_t [$];
    typedef enum int {EV_WRITE, EV_DONE, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       start    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    int         sel      = 0;

    logic        start_v    [2];
    logic        rx_valid_v [2];
    logic        rx_ready_v [2];
    logic        imem_we_v  [2];
    logic [31:0] imem_addr_v  [2];
    logic [31:0] imem_wdata_v [2];
    logic        cpu_hold_v [2];
    logic        busy_v     [2];
    logic        done_v     [2];
    logic        err_v      [2];

    always #5 clk = ~clk;

    assign start_v[0]    = start    && (sel == 0);
    assign start_v[1]    = start    && (sel == 1);
    assign rx_valid_v[0] = rx_valid && (sel == 0);
    assign rx_valid_v[1] = rx_valid && (sel == 1);

    imem_loader u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_v[0]),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid_v[0]),
        .rx_ready   (rx_ready_v[0]),
        .imem_we    (imem_we_v[0]),
        .imem_addr  (imem_addr_v[0]),
        .imem_wdata (imem_wdata_v[0]),
        .cpu_hold   (cpu_hold_v[0]),
        .busy       (busy_v[0]),
        .done       (done_v[0]),
        .err        (err_v[0])
    );

    imem_loader #(.DEPTH_WORDS(SMALL_DEPTH)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_v[1]),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid_v[1]),
        .rx_ready   (rx_ready_v[1]),
        .imem_we    (imem_we_v[1]),
        .imem_addr  (imem_addr_v[1]),
        .imem_wdata (imem_wdata_v[1]),
        .cpu_hold   (cpu_hold_v[1]),
        .busy       (busy_v[1]),
        .done       (done_v[1]),
        .err        (err_v[1])
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_we  [2] = '{0, 0};
    logic err_prev [2] = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    endtask

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        ok = (q_size(d) != 0);
        e  = '{EV_DONE, 32'h0, 32'h0};
        if (ok) e = (d == 0) ? q0.pop_front() : q1.pop_front();
    endtask

    task automatic flush_exp(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    function automatic byte_q_t rand_bytes(input int nbytes);
        byte_q_t b;
        for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    // Reference model: what a whole session must produce, from the length and data bytes.
    task automatic expect_session(input int d, input logic [15:0] n, input byte_q_t data,
                                  output bit exp_err);
        int   depth;
        exp_t e;
        depth   = (d == 0) ? DEPTH_WORDS_DEFAULT : SMALL_DEPTH;
        exp_err = (n == 16'd0) || (int'(n) > depth);
        if (exp_err) begin
            e = '{EV_ERR, 32'h0, 32'h0};
            push_exp(d, e);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                e.kind = EV_WRITE;
                e.addr = 32'(i * 4);
                e.data = {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]};
                push_exp(d, e);
            end
            e = '{EV_DONE, 32'h0, 32'h0};
            push_exp(d, e);
        end
    endtask

    task automatic monitor(input int d);
        exp_t  e;
        bit    ok;
        string p;
        p = $sformatf("dut%0d_", d);
        if (!rst_n) begin
            err_prev[d] = 1'b0;
            return;
        end
        if (imem_we_v[d]) begin
            pop_exp(d, e, ok);
            check({p, "write_expected"}, 32'(ok), 32'd1);
            if (ok) begin
                check({p, "write_kind"}, 32'(e.kind), 32'(EV_WRITE));
                check({p, "write_addr"}, imem_addr_v[d], e.addr);
                check({p, "write_data"}, imem_wdata_v[d], e.data);
            end
            check({p, "hold_during_write"}, 32'(cpu_hold_v[d]), 32'd1);
            check({p, "ready_low_in_write"}, 32'(rx_ready_v[d]), 32'd0);
            last_we[d] = cyc;
        end
        if (done_v[d]) begin
            pop_exp(d, e, ok);
            check({p, "done_expected"}, 32'(ok), 32'd1);
            if (ok) check({p, "done_kind"}, 32'(e.kind), 32'(EV_DONE));
            check({p, "done_latency"}, 32'(cyc - last_we[d]), 32'd1);
            check({p, "busy_at_done"}, 32'(busy_v[d]), 32'd1);
        end
        if (err_v[d] && !err_prev[d]) begin
            pop_exp(d, e, ok);
            check({p, "err_expected"}, 32'(ok), 32'd1);
            if (ok) check({p, "err_kind"}, 32'(e.kind), 32'(EV_ERR));
            check({p, "hold_low_at_err"}, 32'(cpu_hold_v[d]), 32'd0);
        end
        err_prev[d] = err_v[d];
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor(d);
    end

    task automatic check_outputs_zero(input int d, input string tag);
        string p;
        p = $sformatf("dut%0d_%s_", d, tag);
        check({p, "rx_ready"},   32'(rx_ready_v[d]), 32'd0);
        check({p, "imem_we"},    32'(imem_we_v[d]),  32'd0);
        check({p, "cpu_hold"},   32'(cpu_hold_v[d]), 32'd0);
        check({p, "busy"},       32'(busy_v[d]),     32'd0);
        check({p, "done"},       32'(done_v[d]),     32'd0);
        check({p, "err"},        32'(err_v[d]),      32'd0);
        check({p, "imem_addr"},  imem_addr_v[d],     32'd0);
        check({p, "imem_wdata"}, imem_wdata_v[d],    32'd0);
    endtask

    // Offers one byte after 'gap' idle cycles and holds it until the loader takes it.
    task automatic send_byte(input int d, input logic [7:0] b, input int gap);
        bit acc;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = rx_ready_v[d];
            @(posedge clk); #1;
        end
        if (!acc) check($sformatf("dut%0d_byte_accept_timeout", d), 32'd0, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 200 && busy_v[d]; i++) @(negedge clk);
        check($sformatf("dut%0d_idle_reached", d), 32'(busy_v[d]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_session(input int d, input logic [15:0] n, input byte_q_t data,
                               input int gap, input bit start_mid);
        bit    exp_err;
        string p;
        p   = $sformatf("dut%0d_", d);
        sel = d;
        expect_session(d, n, data, exp_err);
        pulse_start();
        check({p, "busy_after_start"}, 32'(busy_v[d]), 32'd1);
        check({p, "err_cleared_by_start"}, 32'(err_v[d]), 32'd0);
        send_byte(d, n[7:0],  (gap < 0) ? $urandom_range(3, 0) : gap);
        send_byte(d, n[15:8], (gap < 0) ? $urandom_range(3, 0) : gap);
        if (!exp_err) begin
            for (int i = 0; i < 4 * int'(n); i++) begin
                if (start_mid && i == 2) pulse_start();
                send_byte(d, data[i], (gap < 0) ? $urandom_range(3, 0) : gap);
            end
        end
        wait_idle(d);
        check({p, "scoreboard_drained"}, 32'(q_size(d)), 32'd0);
        check({p, "err_after_session"}, 32'(err_v[d]), 32'(exp_err));
        check({p, "hold_after_session"}, 32'(cpu_hold_v[d]), 32'd0);
        flush_exp(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t prog;
        byte_q_t none;
        bit      dummy;
        prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};

        #1 rst_n = 1'b0;
        #2;
        check_outputs_zero(0, "reset");
        check_outputs_zero(1, "reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word program, back-to-back bytes, then with 3-cycle stalls.
        run_session(0, 16'd2, prog, 0, 1'b0);
        run_session(0, 16'd2, prog, 3, 1'b0);

        // Zero length errors out; the following start clears the sticky flag.
        run_session(0, 16'd0, none, 0, 1'b0);
        run_session(0, 16'd1, rand_bytes(4), 1, 1'b0);

        // Small memory: one word too many, then exactly full.
        run_session(1, 16'd5, none, 0, 1'b0);
        run_session(1, 16'd4, rand_bytes(16), -1, 1'b0);

        // Start pulse inside DATA must be ignored.
        run_session(0, 16'd2, rand_bytes(8), 0, 1'b1);

        // Reset after six data bytes: word 0 written, word 1 and done still pending.
        sel = 0;
        expect_session(0, 16'd2, prog, dummy);
        pulse_start();
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(0, prog[i], 0);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero(0, "midreset");
        check("dut0_pending_after_reset", 32'(q_size(0)), 32'd2);
        flush_exp(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_session(0, 16'd2, prog, 0, 1'b0);

        // Full default memory and one word past it.
        run_session(0, 16'd256, rand_bytes(1024), 0, 1'b0);
        run_session(0, 16'd257, none, 0, 1'b0);

        for (int s = 0; s < 24; s++) begin
            int          d;
            int          depth;
            int          r;
            logic [15:0] n;
            d     = $urandom_range(1, 0);
            depth = (d == 0) ? DEPTH_WORDS_DEFAULT : SMALL_DEPTH;
            r     = $urandom_range(9, 0);
            if (r == 0)      n = 16'd0;
            else if (r == 1) n = 16'(depth + 1);
            else             n = 16'($urandom_range((depth < 6) ? depth : 6, 1));
            run_session(d, n, rand_bytes(4 * int'(n)), -1, 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH_WORDS, default 256, instruction-memory capacity in 32-bit words (legal range 1..65535).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new load session; sampled only in IDLE.
REQ-005 rx_data  input  8  incoming program byte.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  loader accepts rx_data this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe.
REQ-009 imem_addr  output  32  byte address of word being written, always 4-aligned.
REQ-010 imem_wdata  output  32  word being written.
REQ-011 cpu_hold  output  1  holds monocycle PC/fetch while the memory is being rewritten.
REQ-012 busy  output  1  session in progress.
REQ-013 done  output  1  one-cycle pulse on successful completion.
REQ-014 err  output  1  sticky length error.

Function
REQ-015 States SHALL be IDLE, LEN_LO, LEN_HI, CHECK, DATA, WRITE, DONE, ERR.
REQ-016 A byte transfer SHALL occur only on a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 exactly in LEN_LO, LEN_HI, DATA.
REQ-017 IDLE: start=1 -> LEN_LO, clear err, clear word index and byte counter; start ignored in all other states.
REQ-018 LEN_LO/LEN_HI: accepted bytes form 16-bit word count N, little-endian (first byte = N[7:0]); LEN_HI transfer -> CHECK.
REQ-019 CHECK (one cycle): N=0 or N>DEPTH_WORDS -> ERR; otherwise -> DATA.
REQ-020 DATA: each accepted byte fills the assembly register little-endian (byte k -> bits 8k+7:8k, k=0..3); 4th transfer -> WRITE.
REQ-021 WRITE (exactly one cycle): imem_we=1, imem_addr=word_index*4, imem_wdata=assembled word; latency from 4th byte accept to imem_we SHALL be 1 cycle.
REQ-022 After WRITE: word_index incremented; if new word_index=N -> DONE, else -> DATA with byte counter 0.
REQ-023 DONE (one cycle): done=1, then -> IDLE.
REQ-024 ERR: err=1 held until next start in IDLE... ERR -> IDLE after one cycle, err remains 1 until start accepted.
REQ-025 imem_we SHALL be 0 outside WRITE; imem_addr/imem_wdata don't-care when imem_we=0 but SHALL hold last value.
REQ-026 cpu_hold and busy SHALL be 1 from the cycle after start accepted through the DONE or CHECK-to-ERR cycle inclusive, 0 otherwise.
REQ-027 rx_valid stalls of any length SHALL not lose or duplicate bytes; bytes offered while rx_ready=0 SHALL be ignored.
REQ-028 Word index counter SHALL be 16 bits; address = {14'b0, word_index, 2'b00}; no wrap possible since N<=DEPTH_WORDS.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and drive rx_ready, imem_we, cpu_hold, busy, done, err to 0 and imem_addr, imem_wdata to 0.
REQ-030 Reset mid-session SHALL discard the partial word and count; words already written remain in memory.

Structure
REQ-031 State encoding and the DEPTH_WORDS default SHALL live in a shared package used by monocycle and this block.
REQ-032 One sub-module, byte_assembler (4-byte little-endian packer with byte counter and full flag), SHALL be instantiated.

Verification
REQ-033 start, bytes 02 00 13 00 50 00 93 00 A0 00 -> writes 0x00500013 @0x0, 0x00A00093 @0x4, done pulse 1 cycle after second write.
REQ-034 Same stream with rx_valid low 3 cycles between every byte -> identical writes, no extra imem_we.
REQ-035 Length bytes 00 00 -> err=1, cpu_hold=0, no imem_we; next start clears err.
REQ-036 DEPTH_WORDS=4, length 05 00 -> err=1, no writes; length 04 00 + 16 bytes -> last write at imem_addr 0x0000000C.
REQ-037 rst_n low after 6 data bytes of an N=2 session -> all outputs 0 at once, only word 0 written; new session after release completes normally.
REQ-038 start asserted during DATA -> ignored, session counts unaffected.
